step_sequencer: RTL
===================

Name: step_sequencer

Overview:
- Parametrised instruction-cycle controller and PC owner for the uCISC core.
- Generalises the fixed 4-step fetch/execute cycle to STEPS steps, adding memory wait-state stalls, halt, and single-step debug.
- Sits between the CPU datapath and memory.
- Drives the step index, PC and per-phase enables; datapath decode/ALU logic consumes these.

Parameters:
- STEPS, 4, steps per instruction (2..16).
- STEP_BITS, 2, width of step output; must satisfy 2^STEP_BITS >= STEPS.
- PC_WIDTH, 16, program counter width.
- RESET_PC, 0, PC value loaded on reset.
- CNT_WIDTH, 32, retired-instruction counter width.

Ports:
- clock_input  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  2  00 run, 01 single-step, 10 halt, 11 treated as halt.
- step_req  in  1  single-step request pulse.
- mem_wait  in  1  memory not ready; stalls the current step.
- branch_valid  in  1  sampled on the last step; selects branch_target.
- branch_target  in  PC_WIDTH  next PC when branching.
- inc_words  in  2  instruction length in words (0 treated as 1); sampled on the last step.
- step  out  STEP_BITS  current step index.
- pc  out  PC_WIDTH  program counter.
- fetch_en  out  1  high while step==0 and sequencer active.
- exec_en  out  1  high while step==STEPS-1 and sequencer active.
- retire  out  1  one-cycle pulse after an instruction completes.
- halted  out  1  sequencer idle at an instruction boundary.
- instr_count  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- Reset (sync, active-high): step=0, pc=RESET_PC, state=RUN, halted=0, retire=0, instr_count=0.
  - Applies mid-instruction, aborting it with no PC update.
  - Reset dominates all other inputs.
- State machine: RUN, HALTED, SINGLE.
- RUN:
  - Each cycle with mem_wait=0, step increments.
  - At step==STEPS-1 with mem_wait=0, step wraps to 0 and pc updates:
    - branch_valid=1: pc <= branch_target.
    - otherwise: pc <= pc + inc_words, modulo 2^PC_WIDTH; 0xFFFF+1 wraps to 0x0000 at width 16.
  - retire pulses in the cycle following that edge; instr_count increments (wraps).
  - mem_wait=1 holds step, pc and all enables unchanged on any step, including the last (PC update deferred).
- Halt/single-step take effect only at instruction boundaries.
  - mode!=00 sampled on the last-step completion edge: go to HALTED instead of starting the next instruction (step=0).
  - An instruction in progress always completes.
- HALTED:
  - halted=1; fetch_en=exec_en=0; step=0; pc held.
  - mode==00 → RUN next cycle.
  - mode==01 and step_req=1 → SINGLE.
- SINGLE:
  - Runs exactly one instruction as in RUN, including stalls.
  - Returns to HALTED on completion; ignores mode changes until completion.
  - mode==00 at completion → RUN.
- step_req is ignored outside HALTED; a held-high step_req runs one instruction per HALTED visit.
- branch_valid/branch_target/inc_words are don't-care except on the completing edge of the last step.
- Simultaneous branch and halt request on the last step: the branch is applied and the sequencer halts with pc=branch_target.
- fetch_en/exec_en are combinational from state and step; all other outputs are registered.

Decomposition:
- Shared package ucisc_pkg:
  - mode encodings (MODE_RUN, MODE_STEP, MODE_HALT).
  - sequencer state enum (SEQ_RUN, SEQ_HALTED, SEQ_SINGLE).
  - default PC_WIDTH.
- One natural sub-module: pc_unit (PC register, increment/branch mux, wrap), instantiated by step_sequencer.
- The step counter and FSM stay in the top module.

Test Plan:
- Reset, mode=00, no stalls, inc_words=1 → step cycles 0,1,2,3,0; pc 0x0000→0x0001 after 4 clocks; retire pulses once per 4 clocks; instr_count=5 after 20 clocks.
- mem_wait=1 for 3 cycles during step 1 → step holds at 1 for 3 extra clocks; instruction takes 7 clocks; pc update delayed accordingly.
- branch_valid=1, branch_target=0x0100 at step 3 → pc=0x0100 next cycle; with inc_words=2 and pc=0xFFFF → pc=0x0001.
- mode=10 asserted at step 1 → instruction completes, halted=1 at step 0, pc advanced once and held for 10 clocks; mode=00 → resumes next cycle.
- mode=01 halted; step_req pulse → exactly one instruction (4 clocks) executes, instr_count +1, halted=1 again; step_req mid-instruction ignored.
- reset at step 2 with pc=0x0042 → next cycle step=0, pc=RESET_PC, instr_count=0, retire=0; STEPS=6, STEP_BITS=3 instance cycles 0..5.

Source files
------------

// File: rtl/ucisc_pkg.sv
// Shared uCISC definitions: run-mode encodings, sequencer states and default
// datapath widths used by the instruction-cycle controller.
package ucisc_pkg;

  localparam int DEFAULT_PC_WIDTH = 16;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_RUN  = 2'b00;
  localparam mode_t MODE_STEP = 2'b01;
  localparam mode_t MODE_HALT = 2'b10;

  typedef enum logic [1:0] {
    SEQ_RUN    = 2'b00,
    SEQ_HALTED = 2'b01,
    SEQ_SINGLE = 2'b10
  } seq_state_e;

endpackage

// File: rtl/step_sequencer_pc_unit.sv
// Program counter register for the sequencer: on an instruction completion it
// either takes the branch target or advances by the instruction length.
module pc_unit
  import ucisc_pkg::*;
#(
  parameter int                  PC_WIDTH = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock_input,
  input  logic                reset,
  input  logic                advance,
  input  logic                branch_valid,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic [1:0]          inc_words,
  output logic [PC_WIDTH-1:0] pc
);

  logic [1:0]          words;
  logic [PC_WIDTH-1:0] pc_next;

  // A zero-length instruction is treated as one word; the add wraps naturally.
  assign words   = (inc_words == 2'd0) ? 2'd1 : inc_words;
  assign pc_next = branch_valid ? branch_target : pc + PC_WIDTH'(words);

  always_ff @(posedge clock_input) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (advance) begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Instruction-cycle controller: walks STEPS steps per instruction with memory
// stalls, owns the PC, and supports halt and single-step at instruction boundaries.
module step_sequencer
  import ucisc_pkg::*;
#(
  parameter int                  STEPS     = 4,
  parameter int                  STEP_BITS = 2,
  parameter int                  PC_WIDTH  = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 32
) (
  input  logic                 clock_input,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 step_req,
  input  logic                 mem_wait,
  input  logic                 branch_valid,
  input  logic [PC_WIDTH-1:0]  branch_target,
  input  logic [1:0]           inc_words,
  output logic [STEP_BITS-1:0] step,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 fetch_en,
  output logic                 exec_en,
  output logic                 retire,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [STEP_BITS-1:0] LAST_STEP = STEP_BITS'(STEPS - 1);

  seq_state_e           state, state_next;
  logic [STEP_BITS-1:0] step_next;
  logic                 complete;
  logic                 active;

  // NOTE: every combinational output gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    step_next  = step;
    complete   = 1'b0;
    active     = (state != SEQ_HALTED);
    fetch_en   = 1'b0;
    exec_en    = 1'b0;

    unique case (state)
      SEQ_HALTED: begin
        if (mode == MODE_RUN) begin
          state_next = SEQ_RUN;
        end else if (mode == MODE_STEP && step_req) begin
          state_next = SEQ_SINGLE;
        end
      end
      SEQ_RUN, SEQ_SINGLE: begin
        if (!mem_wait) begin
          if (step == LAST_STEP) begin
            complete  = 1'b1;
            step_next = '0;
            // Both running states resolve the same way at a boundary: mode 00
            // keeps running, anything else parks the sequencer.
            state_next = (mode == MODE_RUN) ? SEQ_RUN : SEQ_HALTED;
          end else begin
            step_next = step + STEP_BITS'(1);
          end
        end
      end
      default: begin
        state_next = SEQ_HALTED;
        step_next  = '0;
      end
    endcase

    fetch_en = active && (step == '0);
    exec_en  = active && (step == LAST_STEP);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock_input) begin
    if (reset) begin
      state       <= SEQ_RUN;
      step        <= '0;
      retire      <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= state_next;
      step        <= step_next;
      retire      <= complete;
      halted      <= (state_next == SEQ_HALTED);
      instr_count <= instr_count + CNT_WIDTH'(complete);
    end
  end

  pc_unit #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .clock_input   (clock_input),
    .reset         (reset),
    .advance       (complete),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .inc_words     (inc_words),
    .pc            (pc)
  );

endmodule
